// File: rtl/rename_pkg.sv
// Shared rename-stage definitions: decode opcode constants, physical tag sizing
// and the renamed micro-op bundle handed to dispatch.
package rename_pkg;

    localparam int NUM_PREG   = 64;
    localparam int PREG_W     = $clog2(NUM_PREG);
    localparam int ARCH_REGS  = 32;
    localparam int FREE_DEPTH = NUM_PREG - ARCH_REGS;
    localparam int FREE_PTR_W = $clog2(FREE_DEPTH);
    localparam int FREE_CNT_W = FREE_PTR_W + 1;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam int REGWRITE_BIT = 6;

    typedef logic [PREG_W-1:0] preg_t;

    typedef struct packed {
        logic [11:0] pc;
        logic [31:0] instr;
        logic [6:0]  c_sig;
        logic [2:0]  alu_sig;
        logic [31:0] imm;
        preg_t       prs1;
        preg_t       prs2;
        preg_t       prd;
        preg_t       old_prd;
        logic        has_rd;
    } renamed_uop_t;

endpackage

// File: rtl/rename_stage_free_list_fifo.sv
// Circular free list of physical tags. Tag 0 is never enqueued; a push into a
// full list is dropped and raises a sticky overflow flag.
module free_list_fifo
    import rename_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pop,
    input  logic                  push,
    input  preg_t                 push_data,
    output preg_t                 head_data,
    output logic [FREE_CNT_W-1:0] count,
    output logic                  overflow
);

    preg_t                 slots [FREE_DEPTH];
    logic [FREE_PTR_W-1:0] head;
    logic [FREE_PTR_W-1:0] tail;
    logic                  push_req;
    logic                  push_ok;
    logic                  pop_ok;

    assign push_req  = push && (push_data != '0);
    assign push_ok   = push_req && (count < FREE_CNT_W'(FREE_DEPTH));
    assign pop_ok    = pop && (count != '0);
    assign head_data = slots[head];

    // After reset the list holds every tag not used by the identity RAT mapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < FREE_DEPTH; j++) begin
                slots[j] <= PREG_W'(ARCH_REGS + j);
            end
            head     <= '0;
            tail     <= '0;
            count    <= FREE_CNT_W'(FREE_DEPTH);
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                slots[tail] <= push_data;
                tail        <= tail + FREE_PTR_W'(1);
            end
            if (pop_ok) begin
                head <= head + FREE_PTR_W'(1);
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
            count <= count + FREE_CNT_W'(push_ok) - FREE_CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/rename_stage.sv
// Register rename stage: RAT lookup, free-list allocation and a one-entry output
// slot to dispatch. Define RENAME_FREE_BYPASS_EN to let a same-cycle free feed an empty list's allocation.
module rename_stage
    import rename_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic [6:0]  c_sig_in,
    input  logic [2:0]  alu_sig_in,
    input  logic [31:0] imm_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_pc,
    output logic [31:0] out_instr,
    output logic [6:0]  out_c_sig,
    output logic [2:0]  out_alu_sig,
    output logic [31:0] out_imm,
    output preg_t       out_prs1,
    output preg_t       out_prs2,
    output preg_t       out_prd,
    output preg_t       out_old_prd,
    output logic        out_has_rd,
    input  logic        free_valid,
    input  preg_t       free_preg,
    output logic        err_overflow
);

    typedef enum logic {EMPTY, FULL} slot_state_t;

    slot_state_t           state;
    preg_t                 rat [ARCH_REGS];
    renamed_uop_t          uop_d;
    renamed_uop_t          uop_q;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic                  needs_alloc;
    logic                  slot_free;
    logic                  accept;
    logic                  bypass;
    logic                  fifo_pop;
    logic                  fifo_push;
    preg_t                 fifo_head;
    logic [FREE_CNT_W-1:0] free_count;

    assign rs1         = instr_in[19:15];
    assign rs2         = instr_in[24:20];
    assign rd          = instr_in[11:7];
    assign needs_alloc = c_sig_in[REGWRITE_BIT] && (rd != 5'd0);
    assign slot_free   = (state == EMPTY) || out_ready;

`ifdef RENAME_FREE_BYPASS_EN
    assign bypass = needs_alloc && free_valid && (free_preg != '0) && (free_count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign in_ready  = slot_free && (!needs_alloc || (free_count != '0) || bypass);
    assign accept    = in_valid && in_ready;
    assign fifo_pop  = accept && needs_alloc && !bypass;
    assign fifo_push = free_valid && !(accept && bypass);

    free_list_fifo u_free_list (
        .clk       (clk),
        .rst_n     (rst_n),
        .pop       (fifo_pop),
        .push      (fifo_push),
        .push_data (free_preg),
        .head_data (fifo_head),
        .count     (free_count),
        .overflow  (err_overflow)
    );

    // Sources see the RAT as it was before this op's own destination update.
    always_comb begin
        uop_d         = '0;
        uop_d.pc      = pc_in;
        uop_d.instr   = instr_in;
        uop_d.c_sig   = c_sig_in;
        uop_d.alu_sig = alu_sig_in;
        uop_d.imm     = imm_in;
        uop_d.prs1    = rat[rs1];
        uop_d.prs2    = rat[rs2];
        if (needs_alloc) begin
            uop_d.prd     = bypass ? free_preg : fifo_head;
            uop_d.old_prd = rat[rd];
            uop_d.has_rd  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat[i] <= PREG_W'(i);
            end
        end else if (accept && needs_alloc) begin
            rat[rd] <= uop_d.prd;
        end
    end

    // Output slot: a held op stays frozen until dispatch takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            uop_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state <= FULL;
                        uop_q <= uop_d;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        if (accept) begin
                            uop_q <= uop_d;
                        end else begin
                            state <= EMPTY;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign out_valid   = (state == FULL);
    assign out_pc      = uop_q.pc;
    assign out_instr   = uop_q.instr;
    assign out_c_sig   = uop_q.c_sig;
    assign out_alu_sig = uop_q.alu_sig;
    assign out_imm     = uop_q.imm;
    assign out_prs1    = uop_q.prs1;
    assign out_prs2    = uop_q.prs2;
    assign out_prd     = uop_q.prd;
    assign out_old_prd = uop_q.old_prd;
    assign out_has_rd  = uop_q.has_rd;

endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: renaming chains, stores/x0, free-list
// exhaustion and refill, output stalls, overflow and reset mid-stall.
module tb_rename_stage;
    import rename_pkg::*;

    localparam logic [6:0] CS_ALU   = 7'b1000000;
    localparam logic [6:0] CS_STORE = 7'b0100100;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] pc_in;
    logic [31:0] instr_in;
    logic [6:0]  c_sig_in;
    logic [2:0]  alu_sig_in;
    logic [31:0] imm_in;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_pc;
    logic [31:0] out_instr;
    logic [6:0]  out_c_sig;
    logic [2:0]  out_alu_sig;
    logic [31:0] out_imm;
    preg_t       out_prs1;
    preg_t       out_prs2;
    preg_t       out_prd;
    preg_t       out_old_prd;
    logic        out_has_rd;
    logic        free_valid;
    preg_t       free_preg;
    logic        err_overflow;

    int checks;
    int failures;

    rename_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pc_in        (pc_in),
        .instr_in     (instr_in),
        .c_sig_in     (c_sig_in),
        .alu_sig_in   (alu_sig_in),
        .imm_in       (imm_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_c_sig    (out_c_sig),
        .out_alu_sig  (out_alu_sig),
        .out_imm      (out_imm),
        .out_prs1     (out_prs1),
        .out_prs2     (out_prs2),
        .out_prd      (out_prd),
        .out_old_prd  (out_old_prd),
        .out_has_rd   (out_has_rd),
        .free_valid   (free_valid),
        .free_preg    (free_preg),
        .err_overflow (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, OPC_RTYPE};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, OPC_ITYPE};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
    endfunction

    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [6:0] cs,
                                 input logic [11:0] pc, input logic [31:0] imm);
        in_valid   = v;
        instr_in   = ins;
        c_sig_in   = cs;
        pc_in      = pc;
        imm_in     = imm;
        alu_sig_in = pc[2:0];
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        out_ready  = 1'b1;
        free_valid = 1'b0;
        free_preg  = '0;
        applyStimulus(1'b0, 32'h0, 7'h0, 12'h0, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_err_overflow", 64'(err_overflow), 64'd0);
        checkOutput("reset_out_prd", 64'(out_prd), 64'd0);
        checkOutput("reset_out_pc", 64'(out_pc), 64'd0);

        // add x5,x1,x2
        applyStimulus(1'b1, enc_r(5'd5, 5'd1, 5'd2), CS_ALU, 12'h100, 32'h0);
        #1;
        checkOutput("add_in_ready", 64'(in_ready), 64'd1);
        tick();
        checkOutput("add_out_valid", 64'(out_valid), 64'd1);
        checkOutput("add_prs1", 64'(out_prs1), 64'd1);
        checkOutput("add_prs2", 64'(out_prs2), 64'd2);
        checkOutput("add_prd", 64'(out_prd), 64'd32);
        checkOutput("add_old_prd", 64'(out_old_prd), 64'd5);
        checkOutput("add_has_rd", 64'(out_has_rd), 64'd1);
        checkOutput("add_pc", 64'(out_pc), 64'h100);
        checkOutput("add_instr", 64'(out_instr), 64'(enc_r(5'd5, 5'd1, 5'd2)));
        checkOutput("add_alu_sig", 64'(out_alu_sig), 64'd0);

        // addi x5,x5,4
        applyStimulus(1'b1, enc_i(5'd5, 5'd5, 12'd4), CS_ALU, 12'h104, 32'd4);
        tick();
        checkOutput("addi_prs1", 64'(out_prs1), 64'd32);
        checkOutput("addi_prd", 64'(out_prd), 64'd33);
        checkOutput("addi_old_prd", 64'(out_old_prd), 64'd32);
        checkOutput("addi_imm", 64'(out_imm), 64'd4);
        checkOutput("addi_alu_sig", 64'(out_alu_sig), 64'd4);

        // add x6,x5,x0
        applyStimulus(1'b1, enc_r(5'd6, 5'd5, 5'd0), CS_ALU, 12'h108, 32'h0);
        tick();
        checkOutput("chain_prs1", 64'(out_prs1), 64'd33);
        checkOutput("chain_prs2_x0", 64'(out_prs2), 64'd0);
        checkOutput("chain_prd", 64'(out_prd), 64'd34);
        checkOutput("chain_old_prd", 64'(out_old_prd), 64'd6);

        // sw x5,0(x1)
        applyStimulus(1'b1, enc_s(5'd5, 5'd1, 12'd0), CS_STORE, 12'h10c, 32'h0);
        tick();
        checkOutput("sw_prs1", 64'(out_prs1), 64'd1);
        checkOutput("sw_prs2", 64'(out_prs2), 64'd33);
        checkOutput("sw_prd", 64'(out_prd), 64'd0);
        checkOutput("sw_old_prd", 64'(out_old_prd), 64'd0);
        checkOutput("sw_has_rd", 64'(out_has_rd), 64'd0);
        checkOutput("sw_c_sig", 64'(out_c_sig), 64'(CS_STORE));

        // add x0,x5,x5
        applyStimulus(1'b1, enc_r(5'd0, 5'd5, 5'd5), CS_ALU, 12'h110, 32'h0);
        tick();
        checkOutput("x0_has_rd", 64'(out_has_rd), 64'd0);
        checkOutput("x0_prd", 64'(out_prd), 64'd0);

        applyStimulus(1'b1, enc_r(5'd7, 5'd1, 5'd1), CS_ALU, 12'h114, 32'h0);
        tick();
        checkOutput("after_noalloc_prd", 64'(out_prd), 64'd35);

        for (int i = 0; i < 28; i++) begin
            applyStimulus(1'b1, enc_r(5'd8, 5'd0, 5'd0), CS_ALU, 12'h200, 32'h0);
            tick();
            checkOutput("drain_prd", 64'(out_prd), 64'(36 + i));
        end

        applyStimulus(1'b1, enc_r(5'd12, 5'd1, 5'd1), CS_ALU, 12'h300, 32'h0);
        #1;
        checkOutput("empty_in_ready", 64'(in_ready), 64'd0);
        tick();
        checkOutput("empty_out_valid", 64'(out_valid), 64'd0);
        free_valid = 1'b1;
        free_preg  = PREG_W'(40);
        #1;
`ifdef RENAME_FREE_BYPASS_EN
        checkOutput("bypass_in_ready", 64'(in_ready), 64'd1);
        tick();
        free_valid = 1'b0;
        checkOutput("bypass_prd", 64'(out_prd), 64'd40);
        checkOutput("bypass_out_valid", 64'(out_valid), 64'd1);
`else
        checkOutput("refill_same_cycle_in_ready", 64'(in_ready), 64'd0);
        tick();
        free_valid = 1'b0;
        #1;
        checkOutput("refill_next_in_ready", 64'(in_ready), 64'd1);
        tick();
        checkOutput("refill_prd", 64'(out_prd), 64'd40);
`endif
        in_valid = 1'b0;

        for (int i = 0; i < 3; i++) begin
            free_valid = 1'b1;
            free_preg  = PREG_W'(5 + i);
            tick();
        end
        free_valid = 1'b0;

        out_ready = 1'b0;
        applyStimulus(1'b1, enc_r(5'd9, 5'd1, 5'd2), CS_ALU, 12'h400, 32'h0);
        #1;
        checkOutput("stall_first_in_ready", 64'(in_ready), 64'd1);
        tick();
        checkOutput("stall_first_prd", 64'(out_prd), 64'd5);
        applyStimulus(1'b1, enc_r(5'd10, 5'd3, 5'd4), CS_ALU, 12'h404, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
            tick();
            checkOutput("stall_hold_prd", 64'(out_prd), 64'd5);
            checkOutput("stall_hold_pc", 64'(out_pc), 64'h400);
            checkOutput("stall_hold_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("release_in_ready", 64'(in_ready), 64'd1);
        tick();
        checkOutput("release_prd", 64'(out_prd), 64'd6);
        checkOutput("release_pc", 64'(out_pc), 64'h404);
        applyStimulus(1'b1, enc_r(5'd11, 5'd9, 5'd10), CS_ALU, 12'h408, 32'h0);
        tick();
        checkOutput("flow_prd", 64'(out_prd), 64'd7);
        checkOutput("flow_prs1", 64'(out_prs1), 64'd5);
        checkOutput("flow_prs2", 64'(out_prs2), 64'd6);
        in_valid = 1'b0;

        for (int i = 0; i < 32; i++) begin
            free_valid = 1'b1;
            free_preg  = PREG_W'(8 + i);
            tick();
        end
        checkOutput("full_no_overflow", 64'(err_overflow), 64'd0);
        free_preg = PREG_W'(50);
        tick();
        checkOutput("overflow_set", 64'(err_overflow), 64'd1);
        free_valid = 1'b0;
        tick();
        checkOutput("overflow_sticky", 64'(err_overflow), 64'd1);
        applyStimulus(1'b1, enc_r(5'd13, 5'd1, 5'd1), CS_ALU, 12'h500, 32'h0);
        tick();
        checkOutput("refilled_head_prd", 64'(out_prd), 64'd8);

        out_ready = 1'b0;
        applyStimulus(1'b1, enc_r(5'd14, 5'd1, 5'd1), CS_ALU, 12'h504, 32'h0);
        tick();
        tick();
        checkOutput("prereset_stall_valid", 64'(out_valid), 64'd1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset_err_overflow", 64'(err_overflow), 64'd0);
        checkOutput("midreset_out_prd", 64'(out_prd), 64'd0);
        checkOutput("midreset_out_pc", 64'(out_pc), 64'd0);

        out_ready = 1'b1;
        applyStimulus(1'b1, enc_r(5'd5, 5'd13, 5'd14), CS_ALU, 12'h600, 32'h0);
        tick();
        checkOutput("postreset_prs1", 64'(out_prs1), 64'd13);
        checkOutput("postreset_prs2", 64'(out_prs2), 64'd14);
        checkOutput("postreset_prd", 64'(out_prd), 64'd32);
        checkOutput("postreset_old_prd", 64'(out_old_prd), 64'd5);
        for (int i = 0; i < 31; i++) begin
            applyStimulus(1'b1, enc_r(5'd8, 5'd0, 5'd0), CS_ALU, 12'h604, 32'h0);
            tick();
            checkOutput("postreset_drain_prd", 64'(out_prd), 64'(33 + i));
        end
        applyStimulus(1'b1, enc_r(5'd9, 5'd0, 5'd0), CS_ALU, 12'h608, 32'h0);
        #1;
        checkOutput("postreset_count32_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Pipelined register-rename stage directly downstream of decode.
- Consumes decode outputs (pc, instr, c_sig, alu_sig, imm) and maps rs1/rs2/rd to physical registers through a 32-entry RAT and a circular free list.
- Presents one renamed micro-op per cycle to dispatch over a valid/ready handshake.
- Commit returns stale physical registers to the free list.

Parameters:
- NUM_PREG, 64, physical register count; must be a power of 2 and greater than 32.
- PREG_W, 6, physical tag width, equal to log2(NUM_PREG).
- FREE_DEPTH, 32, free-list capacity, equal to NUM_PREG-32.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  decode has an instruction.
- in_ready  out  1  stage accepts this cycle.
- pc_in  in  12  instruction PC.
- instr_in  in  32  raw instruction.
- c_sig_in  in  7  control signals; bit6 = RegWrite.
- alu_sig_in  in  3  ALU op.
- imm_in  in  32  immediate.
- out_valid  out  1  renamed op valid.
- out_ready  in  1  dispatch accepts.
- out_pc / out_instr / out_c_sig / out_alu_sig / out_imm  out  12/32/7/3/32  registered copies of the inputs.
- out_prs1, out_prs2  out  PREG_W  source tags.
- out_prd  out  PREG_W  new destination tag; 0 if none.
- out_old_prd  out  PREG_W  previous mapping of rd, for commit to free.
- out_has_rd  out  1  a destination was allocated.
- free_valid  in  1  commit frees one tag.
- free_preg  in  PREG_W  tag to free.
- err_overflow  out  1  sticky: a free was attempted while the list was full.

Behaviour:
- Field extraction: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7].
- needs_alloc = c_sig_in[6] && rd!=0.
- Output slot FSM has two states:
  - EMPTY --accept--> FULL.
  - FULL --(out_ready && !accept)--> EMPTY.
  - FULL --(out_ready && accept)--> FULL.
  - FULL --(!out_ready)--> FULL; all out_* hold stable.
- slot_free = (state==EMPTY) || out_ready.
- in_ready = slot_free && (!needs_alloc || free_count!=0). in_ready depends on instr_in/c_sig_in; in_valid does not depend on in_ready.
- accept = in_valid && in_ready. Latency is one cycle: accepted at edge N, out_valid=1 after edge N.
- Sources read the RAT before this cycle's update, so rs1==rd yields the old mapping. x0 always maps to tag 0 and is never written.
- On accept with needs_alloc:
  - prd = free_list[head]; head++ (wraps mod FREE_DEPTH).
  - old_prd = RAT[rd]; RAT[rd] = prd; out_has_rd=1.
- On accept without needs_alloc: prd=0, old_prd=0, has_rd=0; free list and RAT unchanged.
- Free: if free_valid && free_preg!=0 && count<FREE_DEPTH, then free_list[tail]=free_preg and tail++ (wraps). free_preg==0 is ignored.
- If free_valid with count==FREE_DEPTH: push dropped; err_overflow set until reset.
- Simultaneous pop and push: count unchanged; both pointers advance.
- Reset (rst_n=0 at edge, synchronous):
  - RAT[i]=i.
  - free_list[j]=32+j; head=0, tail=0, count=32.
  - state=EMPTY; out_valid=0 and all out_* = 0; err_overflow=0.
  - Reset mid-stall discards the held op.
- Width rules: count is log2(FREE_DEPTH)+1 bits; pointers are log2(FREE_DEPTH) bits with natural wrap.

Optional Feature:
- Macro RENAME_FREE_BYPASS_EN.
- Defined: when count==0 and a valid free occurs in the same cycle as an allocating input, in_ready=1, and free_preg is used directly as prd without entering the list (count stays 0).
- Undefined: an empty list stalls allocating ops regardless of a same-cycle free; the freed tag enters the list and is usable the next cycle.

Decomposition:
- Shared package rename_pkg holds:
  - Opcode and signal constants already used by decode: RTYPE/ITYPE/LOAD/STORE opcodes, RegWrite bit index 6.
  - NUM_PREG, PREG_W.
  - A renamed_uop struct typedef for the output bundle.
- One natural sub-module: free_list_fifo (circular buffer with push/pop/count/overflow). The RAT stays inline.

Test Plan:
- Reset, then `add x5,x1,x2` (c_sig 1000000) with out_ready=1 -> next cycle prs1=1, prs2=2, prd=32, old_prd=5, has_rd=1.
- Following `addi x5,x5,4` -> prs1=32, prd=33, old_prd=32. A later op reading x5 gets prs1=33.
- `sw x5,0(x1)` (c_sig 0100100) -> has_rd=0, prd=0, count unchanged. An op with rd=x0 also allocates nothing.
- 32 allocating ops with no frees -> the 33rd sees in_ready=0. Assert free_valid with free_preg=40 -> next cycle accepted with prd=40. With RENAME_FREE_BYPASS_EN, acceptance happens in the same cycle.
- out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0, no extra allocation. On release, ops flow one per cycle.
- Push while count==32 -> err_overflow=1 and sticky; rst_n=0 mid-stall -> out_valid=0, count=32, RAT identity.
